// File: rtl/trainled2_pkg.sv
// rtl/trainled2_pkg.sv - shared TrainLED2 timing defaults and encoder state type
package trainled2_pkg;
    localparam int DEF_T_BIT   = 32;
    localparam int DEF_T0H     = 8;
    localparam int DEF_T1H     = 20;
    localparam int DEF_T_LATCH = 256;
    localparam int DEF_CW      = 9;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        LATCH = 2'd3
    } state_e;
endpackage

// File: rtl/trainled2_phase_timer.sv
// rtl/trainled2_phase_timer.sv - loadable down-counter with done flags, shared by all phases
module trainled2_phase_timer #(
    parameter int CW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done,
    output logic          done_next
);
    logic [CW-1:0] cnt_q, cnt_d;

    // Saturates at zero so an un-reloaded counter never wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    assign done      = (cnt_q == '0);
    assign done_next = (cnt_d == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/trainled2_tx_encoder.sv
// rtl/trainled2_tx_encoder.sv - byte stream to TrainLED2 pulse-width serial line with latch gap
module trainled2_tx_encoder
    import trainled2_pkg::*;
#(
    parameter int T_BIT   = DEF_T_BIT,
    parameter int T0H     = DEF_T0H,
    parameter int T1H     = DEF_T1H,
    parameter int T_LATCH = DEF_T_LATCH,
    parameter int CW      = DEF_CW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       dout,
    output logic       busy,
    output logic       underrun
);
    localparam logic [CW-1:0] H0_M1 = CW'(T0H - 1);
    localparam logic [CW-1:0] H1_M1 = CW'(T1H - 1);
    localparam logic [CW-1:0] L0_M1 = CW'(T_BIT - T0H - 1);
    localparam logic [CW-1:0] L1_M1 = CW'(T_BIT - T1H - 1);
    localparam logic [CW-1:0] LA_M1 = CW'(T_LATCH - 1);

    state_e        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          last_q, last_d;
    logic          s_ready_q, s_ready_d;
    logic          dout_q, dout_d;
    logic          busy_q, busy_d;
    logic          underrun_q, underrun_d;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_done;
    logic          tmr_done_next;
    logic          transfer;

    trainled2_phase_timer #(.CW(CW)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (tmr_load),
        .load_val  (tmr_val),
        .done      (tmr_done),
        .done_next (tmr_done_next)
    );

    assign transfer = s_valid && s_ready_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        last_d     = last_q;
        underrun_d = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    shift_d   = s_data;
                    last_d    = s_last;
                    bit_cnt_d = 3'd7;
                    state_d   = HIGH;
                    tmr_load  = 1'b1;
                    tmr_val   = s_data[7] ? H1_M1 : H0_M1;
                end
            end
            HIGH: begin
                if (tmr_done) begin
                    state_d  = LOW;
                    tmr_load = 1'b1;
                    tmr_val  = shift_q[7] ? L1_M1 : L0_M1;
                end
            end
            LOW: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (bit_cnt_q != 3'd0) begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        shift_d   = {shift_q[6:0], 1'b0};
                        state_d   = HIGH;
                        tmr_val   = shift_q[6] ? H1_M1 : H0_M1;
                    end else if (last_q) begin
                        state_d = LATCH;
                        tmr_val = LA_M1;
                    end else if (transfer) begin
                        shift_d   = s_data;
                        last_d    = s_last;
                        bit_cnt_d = 3'd7;
                        state_d   = HIGH;
                        tmr_val   = s_data[7] ? H1_M1 : H0_M1;
                    end else begin
                        tmr_load   = 1'b0;
                        underrun_d = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            LATCH: begin
                if (tmr_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        dout_d    = (state_d == HIGH);
        busy_d    = (state_d != IDLE);
        s_ready_d = (state_d == IDLE) ||
                    ((state_d == LOW) && tmr_done_next && (bit_cnt_d == 3'd0) && !last_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            last_q     <= 1'b0;
            s_ready_q  <= 1'b0;
            dout_q     <= 1'b0;
            busy_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            last_q     <= last_d;
            s_ready_q  <= s_ready_d;
            dout_q     <= dout_d;
            busy_q     <= busy_d;
            underrun_q <= underrun_d;
        end
    end

    assign s_ready  = s_ready_q;
    assign dout     = dout_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;
endmodule
